// File: rtl/bcd_timer.sv
// BCD min/sec/sub-second timer: prescaled up/down counting, clamped load, lap capture,
// wrap carry-out pulse and optional stop-at-zero countdown with a sticky done flag.
module bcd_timer #(
    parameter int unsigned SUB_MAX      = 9,
    parameter int unsigned MIN_MAX      = 59,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned STOP_AT_ZERO = 1
) (
    input  logic       clk,
    input  logic       r,
    input  logic       en,
    input  logic       run,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] ld_q0,
    input  logic [7:0] ld_qs,
    input  logic [7:0] ld_qm,
    input  logic       lap,
    output logic [3:0] q0,
    output logic [7:0] qs,
    output logic [7:0] qm,
    output logic [3:0] lap_q0,
    output logic [7:0] lap_qs,
    output logic [7:0] lap_qm,
    output logic       co,
    output logic       done
);

    localparam int unsigned    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [3:0]     SUB_BCD  = 4'(SUB_MAX);
    localparam logic [7:0]     SEC_BCD  = 8'h59;
    localparam logic [7:0]     MIN_BCD  = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
    localparam bit             STOP     = (STOP_AT_ZERO != 0);

    logic [PRE_W-1:0] pre;
    logic [3:0]       nq0, cq0;
    logic [7:0]       nqs, nqm, cqs, cqm;
    logic             wrap;
    logic             strobe;
    logic             step_ok;
    logic             is_zero;
    logic             hit_zero;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    // For well-formed BCD, unsigned ordering equals decimal ordering.
    function automatic logic [7:0] clamp2(input logic [7:0] v, input logic [7:0] max_bcd);
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > max_bcd)) return max_bcd;
        return v;
    endfunction

    assign cq0      = (ld_q0 > SUB_BCD) ? SUB_BCD : ld_q0;
    assign cqs      = clamp2(ld_qs, SEC_BCD);
    assign cqm      = clamp2(ld_qm, MIN_BCD);
    assign strobe   = run && en;
    assign is_zero  = (q0 == 4'd0) && (qs == 8'h00) && (qm == 8'h00);
    assign step_ok  = up || !(STOP && done);
    assign hit_zero = STOP && !up && (nq0 == 4'd0) && (nqs == 8'h00) && (nqm == 8'h00);

    // Value after one step in the current direction.
    always_comb begin
        nq0  = q0;
        nqs  = qs;
        nqm  = qm;
        wrap = 1'b0;
        if (up) begin
            if (q0 == SUB_BCD) begin
                nq0 = 4'd0;
                if (qs == SEC_BCD) begin
                    nqs = 8'h00;
                    if (qm == MIN_BCD) begin
                        nqm  = 8'h00;
                        wrap = 1'b1;
                    end else begin
                        nqm = bcd_inc(qm);
                    end
                end else begin
                    nqs = bcd_inc(qs);
                end
            end else begin
                nq0 = q0 + 4'd1;
            end
        end else if (is_zero) begin
            if (!STOP) begin
                nq0  = SUB_BCD;
                nqs  = SEC_BCD;
                nqm  = MIN_BCD;
                wrap = 1'b1;
            end
        end else begin
            if (q0 == 4'd0) begin
                nq0 = SUB_BCD;
                if (qs == 8'h00) begin
                    nqs = SEC_BCD;
                    nqm = (qm == 8'h00) ? MIN_BCD : bcd_dec(qm);
                end else begin
                    nqs = bcd_dec(qs);
                end
            end else begin
                nq0 = q0 - 4'd1;
            end
        end
    end

    // Counter value, prescaler and flags: r > load > step.
    always_ff @(posedge clk) begin
        if (r) begin
            q0   <= 4'd0;
            qs   <= 8'h00;
            qm   <= 8'h00;
            pre  <= '0;
            co   <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            q0   <= cq0;
            qs   <= cqs;
            qm   <= cqm;
            pre  <= '0;
            co   <= 1'b0;
            done <= 1'b0;
        end else begin
            co <= 1'b0;
            if (strobe) begin
                if (pre == PRE_LAST) begin
                    pre <= '0;
                    if (step_ok) begin
                        q0 <= nq0;
                        qs <= nqs;
                        qm <= nqm;
                        co <= wrap;
                        if (hit_zero) done <= 1'b1;
                    end
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end
        end
    end

    // Lap capture sees the pre-edge value and outranks a coincident reset.
    always_ff @(posedge clk) begin
        if (lap) begin
            lap_q0 <= q0;
            lap_qs <= qs;
            lap_qm <= qm;
        end else if (r) begin
            lap_q0 <= 4'd0;
            lap_qs <= 8'h00;
            lap_qm <= 8'h00;
        end
    end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised BCD minutes/seconds/sub-second timer, the next generation of the team's timing counter. It counts a qualified enable strobe through a prescaler into a three-field BCD display value (sub-second digit, seconds 00–59, minutes 00–MIN_MAX). It adds up/down direction, parallel load, lap capture, wrap carry-out and stop-at-zero countdown. It sits between the tick generator and the 7-segment display/scan logic.

## Interface
- SUB_MAX, 9: maximum sub-second digit value, 1..9.
- MIN_MAX, 59: maximum minutes value, decimal 1..99.
- PRESCALE, 1: qualified en strobes per sub-second step, 1..256.
- STOP_AT_ZERO, 1: 1 = down-count halts at zero and raises done; 0 = down-count wraps to maximum.

- clk  in  1  rising-edge clock, single clock domain.
- r  in  1  reset, synchronous, active-high.
- en  in  1  count strobe; one clk wide per tick.
- run  in  1  1 = counting enabled; 0 = paused (prescaler and value hold).
- up  in  1  1 = count up, 0 = count down.
- load  in  1  parallel load of ld_q0/ld_qs/ld_qm.
- ld_q0  in  4  load value, sub-second digit.
- ld_qs  in  8  load value, seconds, two BCD digits.
- ld_qm  in  8  load value, minutes, two BCD digits.
- lap  in  1  capture current value into lap registers.
- q0  out  4  sub-second digit.
- qs  out  8  seconds BCD, 8'h00..8'h59.
- qm  out  8  minutes BCD, 8'h00..MIN_MAX.
- lap_q0 / lap_qs / lap_qm  out  4/8/8  captured value.
- co  out  1  one-cycle pulse on full-range wrap in either direction.
- done  out  1  sticky countdown-reached-zero flag.

## Operation
- Priority each edge: r > load > step. lap is independent of that priority.
- Prescaler pre counts 0..PRESCALE-1 on each edge with run&en. A step occurs when run&en and pre==PRESCALE-1, and pre then returns to 0. With PRESCALE=1, every run&en is a step.
- Up step:
  - q0 increments; at SUB_MAX it goes to 0 and carries into qs.
  - qs increments in BCD (low nibble 9 → 0 with high-nibble increment); at 8'h59 it goes to 8'h00 and carries into qm.
  - qm increments in BCD; at MIN_MAX it goes to 8'h00 and co=1.
- Down step: mirror of up. q0 at 0 goes to SUB_MAX and borrows; qs at 8'h00 goes to 8'h59 and borrows; qm at 8'h00 goes to MIN_MAX.
- Down step from all-zero:
  - STOP_AT_ZERO=1: value holds, no co.
  - STOP_AT_ZERO=0: wraps to all-maximum, co=1.
- done (STOP_AT_ZERO=1 only):
  - Set on the edge where a down step yields 00/00/0.
  - Cleared only by r or load.
  - While done=1, down steps are ignored; up steps proceed and do not clear done.
- Load:
  - Each field is clamped independently. Any nibble >9, or a field value above its maximum (SUB_MAX, 59, MIN_MAX), loads that field's maximum instead.
  - Load clears pre, co and done.
  - Loading zero while up=0 does not set done.
- lap=1 copies q0/qs/qm as they stand before this edge's update into lap_*. This holds even if the same edge steps, loads or resets.
- direction change takes effect on the next step; pre is not cleared.
- run=0 freezes pre, value and done; load and lap still act.

## Timing
- All outputs are registered. The value changes on the clk edge that samples the qualifying step, so it is visible one cycle after the strobe is presented.
- co is asserted for exactly the one cycle following the wrapping edge; it is 0 otherwise.
- done rises together with the value reaching zero.
- Reset (1 cycle sufficient, mid-count allowed): q0=0, qs=8'h00, qm=8'h00, lap_*=0, co=0, done=0, pre=0.
- Simultaneous r and lap: lap captures the pre-reset value, then all other state resets. lap_* is not cleared by that reset.
- Simultaneous load and step: load wins and the step is discarded (pre cleared).

## Test plan
- Reset: r=1 for one cycle mid-count at 03:27.5 → next cycle all outputs 0, co=0, done=0.
- Prescale, PRESCALE=4, up, run=1, en every cycle: 40 strobes → q0=0, qs=8'h01, qm=8'h00. run=0 for 10 cycles → no change.
- Up wrap at defaults: load 59/59/9, one step → 00/00/0, co=1 for exactly one cycle, then 0.
- Countdown, STOP_AT_ZERO=1: load 00/00/2, up=0, 3 steps → 00/00/1, 00/00/0 with done=1, then held at zero with done still 1. load 00/10/0 → done=0.
- Load clamp and priority: ld_q0=4'hC, ld_qs=8'h75, ld_qm=8'h3A → q0=9, qs=8'h59, qm=8'h59. load coincident with a step → loaded value only.
- Lap/step coincidence: at 00/09/9 up, lap and step on the same edge → lap=00/09/9 and q=00/10/0. Down-step borrow from 01/00/0 → 00/59/SUB_MAX.
